// File: rtl/cvita_chunker_pkg.sv
// cvita_chunker_pkg
// Shared CVITA definitions for the chunker: header length field position,
// word size, FSM state encoding and a helper that converts the header byte
// length into a 64-bit word count.
package cvita_chunker_pkg;

  localparam int CVITA_LEN_MSB    = 47;
  localparam int CVITA_LEN_LSB    = 32;
  localparam int CVITA_WORD_BYTES = 8;
  localparam int CVITA_WORD_SHIFT = $clog2(CVITA_WORD_BYTES);

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_DATA   = 2'd1,
    ST_PAD    = 2'd2,
    ST_ERROR  = 2'd3
  } chunk_state_t;

  // Words occupied by a packet whose header claims len_bytes bytes.
  // Computed one bit wider than the length field so a length near 64 KiB
  // cannot wrap during the round-up, and never less than one word because
  // the header itself always occupies a word.
  function automatic logic [16:0] hdr_words(input logic [15:0] len_bytes);
    logic [16:0] words;
    words = ({1'b0, len_bytes} + 17'(CVITA_WORD_BYTES - 1)) >> CVITA_WORD_SHIFT;
    if (words == 17'd0) begin
      words = 17'd1;
    end
    return words;
  endfunction

endpackage

// File: rtl/cvita_chunker_flop2.sv
// axi_fifo_flop2
// Two-entry AXI-stream register stage. The output register feeds o_* and a
// skid register catches one word when the consumer stalls, so the upstream
// ready is fully registered while throughput stays at one word per cycle.
// An accepted word appears on o_tvalid one cycle later.
//
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   clear          synchronous flush of both entries
//   i_tdata/i_tvalid/i_tready   upstream stream
//   o_tdata/o_tvalid/o_tready   downstream stream
module axi_fifo_flop2 #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             push;

  // Upstream may push whenever the skid slot is free; the output register
  // is either free or about to move into the skid slot.
  assign i_tready = !skid_valid;
  assign push     = i_tvalid && i_tready;

  // Output register refills from the skid slot first so ordering is kept,
  // otherwise straight from the input. When the output is held by back-
  // pressure, a newly pushed word parks in the skid slot.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      o_tdata    <= '0;
      o_tvalid   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else begin
      if (!o_tvalid || o_tready) begin
        if (skid_valid) begin
          o_tdata    <= skid_data;
          o_tvalid   <= 1'b1;
          skid_valid <= 1'b0;
        end else if (push) begin
          o_tdata  <= i_tdata;
          o_tvalid <= 1'b1;
        end else begin
          o_tvalid <= 1'b0;
        end
      end else if (push) begin
        skid_data  <= i_tdata;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cvita_chunker.sv
// cvita_chunker
// Transmit-side framer for CVITA streams. Each incoming packet is forwarded
// unchanged and followed by PAD_VALUE words until exactly frame_q words have
// been emitted; o_tlast marks the final word of every frame. Packets whose
// header length cannot fit in a frame, or that run past the frame without
// ending, raise a sticky error and all further input is swallowed until
// clear or reset.
//
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   clear          synchronous soft reset, also re-samples frame_size
//   frame_size     frame length in 64-bit words (sampled at reset/clear)
//   i_tdata/i_tlast/i_tvalid/i_tready   input CVITA packet stream
//   o_tdata/o_tlast/o_tvalid/o_tready   output fixed-size frame stream
//   error          sticky oversize/protocol error flag
module cvita_chunker
  import cvita_chunker_pkg::*;
#(
  parameter logic [63:0] PAD_VALUE = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] frame_size,
  input  logic [63:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [63:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             error
);

  chunk_state_t     state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [CNT_W-1:0] frame_q;
  logic             error_next;

  logic [CNT_W-1:0] count_inc;
  logic             at_end;
  logic             hdr_bad;

  logic             s_valid;
  logic             s_last;
  logic [63:0]      s_data;
  logic             f_ready;
  logic [64:0]      f_out;

  // count holds the words already emitted in the current frame, so the word
  // being offered now is number count_inc. In ST_HEADER count is zero.
  assign count_inc = count + CNT_W'(1);
  assign at_end    = (count_inc == frame_q);
  assign hdr_bad   = (frame_q == '0) ||
                     (hdr_words(i_tdata[CVITA_LEN_MSB:CVITA_LEN_LSB]) > {1'b0, frame_q});

  // State, word counter, sampled frame length and sticky error. Reset and
  // clear have the same effect here; any packet in flight is abandoned.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state   <= ST_HEADER;
      count   <= '0;
      error   <= 1'b0;
      frame_q <= frame_size;
    end else begin
      state <= state_next;
      count <= count_next;
      error <= error_next;
    end
  end

  // Next-state and stage outputs. The stage offers one word at a time to
  // the output flop; input is only consumed when the flop accepts, except
  // in ST_ERROR where input is drained and dropped. A header that claims
  // more words than the frame holds is consumed but never emitted. A packet
  // that reaches the frame end without tlast gets its last word marked as
  // frame end and then the block locks in ST_ERROR; this also covers a
  // one-word frame whose header word arrives without tlast.
  always_comb begin
    state_next = state;
    count_next = count;
    error_next = error;
    i_tready   = 1'b0;
    s_valid    = 1'b0;
    s_data     = i_tdata;
    s_last     = at_end;

    case (state)
      ST_HEADER: begin
        i_tready = f_ready;
        s_valid  = i_tvalid && !hdr_bad;
        if (i_tvalid && f_ready) begin
          if (hdr_bad) begin
            error_next = 1'b1;
            state_next = ST_ERROR;
          end else if (at_end) begin
            count_next = '0;
            if (!i_tlast) begin
              error_next = 1'b1;
              state_next = ST_ERROR;
            end
          end else begin
            count_next = count_inc;
            state_next = i_tlast ? ST_PAD : ST_DATA;
          end
        end
      end

      ST_DATA: begin
        i_tready = f_ready;
        s_valid  = i_tvalid;
        if (i_tvalid && f_ready) begin
          if (at_end) begin
            count_next = '0;
            if (i_tlast) begin
              state_next = ST_HEADER;
            end else begin
              error_next = 1'b1;
              state_next = ST_ERROR;
            end
          end else begin
            count_next = count_inc;
            if (i_tlast) begin
              state_next = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        s_valid = 1'b1;
        s_data  = PAD_VALUE;
        if (f_ready) begin
          if (at_end) begin
            count_next = '0;
            state_next = ST_HEADER;
          end else begin
            count_next = count_inc;
          end
        end
      end

      ST_ERROR: begin
        i_tready = 1'b1;
      end

      default: begin
        state_next = ST_HEADER;
      end
    endcase
  end

  axi_fifo_flop2 #(
    .WIDTH (65)
  ) out_flop (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .i_tdata  ({s_last, s_data}),
    .i_tvalid (s_valid),
    .i_tready (f_ready),
    .o_tdata  (f_out),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
  );

  assign o_tlast = f_out[64];
  assign o_tdata = f_out[63:0];

endmodule

// File: tb/tb_cvita_chunker.sv
// tb_cvita_chunker
// Directed bench for cvita_chunker: a table of packet vectors with hand-
// computed output/input counts and error state, a behavioural frame model
// for word-by-word comparison, and hand-written sequences for back-to-back
// packets, error timing and reset in the middle of padding.
module tb_cvita_chunker;

  localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [15:0] frame_size;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        error;

  int          total = 0;
  int          bad = 0;
  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];
  int          in_count;
  bit          model_err;
  bit          stall_en;
  bit          hold_prev;
  logic [64:0] hold_word;

  typedef struct {
    int frame;
    int len;
    int nwords;
    bit do_clear;
    bit stall;
    int exp_out;
    int exp_in;
    bit exp_err;
  } vec_t;

  vec_t vecs[14];

  cvita_chunker #(
    .PAD_VALUE (PAD),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .frame_size (frame_size),
    .i_tdata    (i_tdata),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .error      (error)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] mkWord(input int tag, input int idx, input int len);
    if (idx == 0) begin
      return {16'hCAFE, 16'(len), 16'(tag), 16'h0000};
    end
    return {16'(tag), 16'h5A5A, 16'h0000, 16'(idx)};
  endfunction

  task automatic checkVal(input string name, input logic [64:0] got, input logic [64:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Output collector, input transfer counter and hold-stability checker.
  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (hold_prev) begin
        checkVal("hold_stable", {15'd0, o_tvalid, o_tlast, o_tdata[63:16]},
                 {15'd0, 1'b1, hold_word[64:16]});
        checkVal("hold_low", {49'd0, o_tdata[15:0]}, {49'd0, hold_word[15:0]});
      end
      hold_prev = o_tvalid && !o_tready && reset_n && !clear;
      hold_word = {o_tlast, o_tdata};
      if (reset_n && !clear) begin
        if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tdata});
        if (i_tvalid && i_tready) in_count++;
      end
    end
  endtask

  task automatic readyLoop();
    forever begin
      @(posedge clk);
      #1;
      o_tready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  endtask

  task automatic sendWord(input logic [63:0] d, input logic l);
    bit hs;
    hs = 1'b0;
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    for (int c = 0; c < 500 && !hs; c++) begin
      @(negedge clk);
      hs = i_tready;
      @(posedge clk);
    end
    #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    if (!hs) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout: got i_tready=0 for 500 cycles want 1");
    end
  endtask

  task automatic sendPacket(input int len, input int n, input int tag);
    for (int i = 0; i < n; i++) sendWord(mkWord(tag, i, len), i == n - 1);
  endtask

  task automatic doClear(input int f);
    @(posedge clk);
    #1;
    frame_size = 16'(f);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_err = 1'b0;
    in_count = 0;
  endtask

  task automatic waitOutputs(input int n);
    for (int c = 0; c < 3000 && got_q.size() < n; c++) @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Expected frame contents for one packet given the frame length in force.
  task automatic modelPacket(input int frame, input int len, input int n, input int tag);
    int hw;
    logic [63:0] w;
    if (model_err) return;
    hw = (len + 7) / 8;
    if (hw < 1) hw = 1;
    if (frame == 0 || hw > frame) begin
      model_err = 1'b1;
      return;
    end
    for (int k = 1; k <= n; k++) begin
      w = mkWord(tag, k - 1, len);
      if (k == n) begin
        exp_q.push_back({k == frame, w});
        for (int j = k + 1; j <= frame; j++) exp_q.push_back({j == frame, PAD});
        return;
      end
      if (k == frame) begin
        exp_q.push_back({1'b1, w});
        model_err = 1'b1;
        return;
      end
      exp_q.push_back({1'b0, w});
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    if (v.do_clear) begin
      doClear(v.frame);
      checkVal($sformatf("v%0d_clr_err", tag), {64'd0, error}, 65'd0);
      checkVal($sformatf("v%0d_clr_valid", tag), {64'd0, o_tvalid}, 65'd0);
    end
    stall_en = v.stall;
    modelPacket(v.frame, v.len, v.nwords, tag);
    sendPacket(v.len, v.nwords, tag);
    waitOutputs(v.exp_out);
    stall_en = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int exp_out, input int exp_in, input bit exp_err);
    logic [64:0] g;
    checkVal({name, "_out_count"}, 65'(got_q.size()), 65'(exp_out));
    checkVal({name, "_in_count"}, 65'(in_count), 65'(exp_in));
    checkVal({name, "_error"}, {64'd0, error}, {64'd0, exp_err});
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      checkVal($sformatf("%s_word%0d", name, i), g, exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
    in_count = 0;
  endtask

  initial begin
    vecs[0]  = '{8,  32, 4,  1'b1, 1'b0, 8,  4,  1'b0};
    vecs[1]  = '{10, 80, 10, 1'b1, 1'b0, 10, 10, 1'b0};
    vecs[2]  = '{10, 72, 9,  1'b0, 1'b0, 10, 9,  1'b0};
    vecs[3]  = '{10, 88, 11, 1'b0, 1'b0, 0,  11, 1'b1};
    vecs[4]  = '{10, 32, 4,  1'b0, 1'b0, 0,  4,  1'b1};
    vecs[5]  = '{10, 64, 8,  1'b1, 1'b0, 10, 8,  1'b0};
    vecs[6]  = '{8,  8,  1,  1'b1, 1'b0, 8,  1,  1'b0};
    vecs[7]  = '{10, 72, 9,  1'b1, 1'b1, 10, 9,  1'b0};
    vecs[8]  = '{10, 8,  1,  1'b0, 1'b1, 10, 1,  1'b0};
    vecs[9]  = '{8,  16, 9,  1'b1, 1'b0, 8,  9,  1'b1};
    vecs[10] = '{1,  8,  1,  1'b1, 1'b0, 1,  1,  1'b0};
    vecs[11] = '{1,  8,  1,  1'b0, 1'b0, 1,  1,  1'b0};
    vecs[12] = '{1,  16, 2,  1'b0, 1'b0, 0,  2,  1'b1};
    vecs[13] = '{0,  8,  1,  1'b1, 1'b0, 0,  1,  1'b1};

    reset_n    = 1'b0;
    clear      = 1'b0;
    frame_size = 16'd8;
    i_tdata    = '0;
    i_tlast    = 1'b0;
    i_tvalid   = 1'b0;
    o_tready   = 1'b1;
    stall_en   = 1'b0;
    hold_prev  = 1'b0;
    hold_word  = '0;
    in_count   = 0;
    model_err  = 1'b0;
    fork
      monitorLoop();
      readyLoop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkVal("rst_valid", {64'd0, o_tvalid}, 65'd0);
    checkVal("rst_tlast", {64'd0, o_tlast}, 65'd0);
    checkVal("rst_tdata", {1'b0, o_tdata}, 65'd0);
    checkVal("rst_error", {64'd0, error}, 65'd0);
    checkVal("rst_ready", {64'd0, i_tready}, 65'd1);

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v], v + 1);
      checkOutput($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_in, vecs[v].exp_err);
    end

    // Error flag must rise the cycle right after an oversize header.
    doClear(10);
    checkVal("errt_pre", {64'd0, error}, 65'd0);
    modelPacket(10, 88, 1, 40);
    sendWord(mkWord(40, 0, 88), 1'b1);
    @(negedge clk);
    checkVal("errt_error", {64'd0, error}, 65'd1);
    checkVal("errt_valid", {64'd0, o_tvalid}, 65'd0);
    waitOutputs(0);
    checkOutput("errt", 0, 1, 1'b1);

    // Back-to-back packets of 1..4 words into 8-word frames.
    doClear(8);
    for (int p = 1; p <= 4; p++) begin
      modelPacket(8, p * 8, p, 50 + p);
      sendPacket(p * 8, p, 50 + p);
    end
    waitOutputs(32);
    checkVal("b2b_last_word", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 'x, {1'b1, PAD});
    checkOutput("b2b", 32, 10, 1'b0);

    // Reset in the middle of padding, then a clean packet.
    sendPacket(8, 1, 60);
    for (int c = 0; c < 500 && got_q.size() < 3; c++) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkVal("midpad_rst_valid", {64'd0, o_tvalid}, 65'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    in_count  = 0;
    model_err = 1'b0;
    modelPacket(8, 16, 2, 61);
    sendPacket(16, 2, 61);
    waitOutputs(8);
    checkOutput("post_reset", 8, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
